// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for the sequential floating-point divider.
// Both directions use valid/ready; the divider sits on the slave modport.
interface fp_div_seq_if #(
    parameter int W_MANTISSA = 10,
    parameter int W_EXPONENT = 5
);
    localparam int W = W_MANTISSA + W_EXPONENT + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_x;
    logic         overflow;
    logic         underflow;
    logic         exception;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_x, overflow, underflow, exception
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_x, overflow, underflow, exception
    );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential floating-point divider, out_x = in_a / in_b, restoring division
// one quotient bit per cycle; fixed latency including the special cases.
module fp_div_seq #(
    parameter int W_MANTISSA = 10,
    parameter int W_EXPONENT = 5
) (
    input logic          clk,
    input logic          rst_n,
    fp_div_seq_if.slave  bus
);
    localparam int W  = W_MANTISSA + W_EXPONENT + 1;
    localparam int EW = W_EXPONENT + 2;
    localparam int CW = $clog2(W_MANTISSA + 2);

    localparam logic signed [EW-1:0] EXP_BIAS = EW'(2 ** (W_EXPONENT - 1) - 1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'(2 ** W_EXPONENT - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(W_MANTISSA + 1);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic                    sign_r;
    logic signed [EW-1:0]    exp_r;
    logic [W_MANTISSA+1:0]   rem;
    logic [W_MANTISSA:0]     dvs;
    logic [W_MANTISSA+1:0]   q;
    logic                    a_zero;
    logic                    b_zero;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [W-1:0]            out_x_r;
    logic                    ovf_r;
    logic                    unf_r;
    logic                    exc_r;

    logic                    ge;
    logic [W_MANTISSA+1:0]   rem_next;
    logic [W_MANTISSA-1:0]   mant_n;
    logic signed [EW-1:0]    exp_n;

    // Restoring step and post-division normalisation.
    always_comb begin
        ge       = rem >= {1'b0, dvs};
        rem_next = ge ? (rem - {1'b0, dvs}) : rem;
        if (q[W_MANTISSA+1]) begin
            mant_n = q[W_MANTISSA:1];
            exp_n  = exp_r;
        end else begin
            mant_n = q[W_MANTISSA-1:0];
            exp_n  = exp_r - EXP_ONE;
        end
    end

    // NOTE: all state below is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
            rem         <= '0;
            dvs         <= '0;
            q           <= '0;
            a_zero      <= 1'b0;
            b_zero      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_x_r     <= '0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            exc_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        state      <= DIV;
                        in_ready_r <= 1'b0;
                        cnt        <= '0;
                        q          <= '0;
                        sign_r     <= bus.in_a[W-1] ^ bus.in_b[W-1];
                        exp_r      <= signed'({2'b00, bus.in_a[W-2:W_MANTISSA]})
                                    - signed'({2'b00, bus.in_b[W-2:W_MANTISSA]})
                                    + EXP_BIAS;
                        rem        <= {2'b01, bus.in_a[W_MANTISSA-1:0]};
                        dvs        <= {1'b1, bus.in_b[W_MANTISSA-1:0]};
                        // Exponent 0 is zero; denormal mantissas are ignored.
                        a_zero     <= (bus.in_a[W-2:W_MANTISSA] == '0);
                        b_zero     <= (bus.in_b[W-2:W_MANTISSA] == '0);
                    end
                end

                DIV: begin
                    q   <= {q[W_MANTISSA:0], ge};
                    rem <= rem_next << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= NORM;
                end

                NORM: begin
                    ovf_r <= 1'b0;
                    unf_r <= 1'b0;
                    exc_r <= 1'b0;
                    if (b_zero) begin
                        out_x_r <= {sign_r, {(W-1){1'b1}}};
                        exc_r   <= 1'b1;
                    end else if (a_zero) begin
                        out_x_r <= {sign_r, {(W-1){1'b0}}};
                    end else if (exp_n <= EXP_ZERO) begin
                        out_x_r <= {sign_r, {(W-1){1'b0}}};
                        unf_r   <= 1'b1;
                    end else if (exp_n > EXP_MAX) begin
                        out_x_r <= {sign_r, {(W-1){1'b1}}};
                        ovf_r   <= 1'b1;
                    end else begin
                        out_x_r <= {sign_r, exp_n[W_EXPONENT-1:0], mant_n};
                    end
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end

                DONE: begin
                    // in_ready rises only after the handshake edge, so a
                    // result and a new accept never share a cycle.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_x     = out_x_r;
    assign bus.overflow  = ovf_r;
    assign bus.underflow = unf_r;
    assign bus.exception = exc_r;
endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed table, backpressure and reset
// sequences, then random operands against a real-arithmetic reference model.
module tb_fp_div_seq;
    localparam int WM  = 10;
    localparam int WE  = 5;
    localparam int W   = WM + WE + 1;
    localparam int LAT = WM + 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_div_seq_if #(.W_MANTISSA(WM), .W_EXPONENT(WE)) bus ();

    fp_div_seq #(.W_MANTISSA(WM), .W_EXPONENT(WE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // flags packed as {overflow, underflow, exception}
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] x;
        logic [2:0]   flags;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Reference: value = 1.m * 2^(e-15); quotient formed in real arithmetic,
    // normalised into [1,2) and truncated to 10 fraction bits.
    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] x, output logic [2:0] flags);
        int   ea = int'(a[14:10]);
        int   eb = int'(b[14:10]);
        int   ma = int'(a[9:0]);
        int   mb = int'(b[9:0]);
        logic s  = a[15] ^ b[15];
        int   e;
        int   mant;
        real  r;
        flags = 3'b000;
        if (eb == 0) begin
            x = {s, 15'h7FFF};
            flags = 3'b001;
        end else if (ea == 0) begin
            x = {s, 15'h0000};
        end else begin
            r = real'(1024 + ma) / real'(1024 + mb);
            e = ea - eb + 15;
            if (r < 1.0) begin
                r = r * 2.0;
                e = e - 1;
            end
            mant = $rtoi((r - 1.0) * 1024.0);
            if (e <= 0) begin
                x = {s, 15'h0000};
                flags = 3'b010;
            end else if (e > 31) begin
                x = {s, 15'h7FFF};
                flags = 3'b100;
            end else begin
                x = {s, 5'(e), 10'(mant)};
            end
        end
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts rising edges after the accepting edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_and_check(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] x_exp, input logic [2:0] f_exp,
                                 input string tag, input int hold);
        int lat;
        send(a, b);
        wait_result(lat);
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        repeat (hold) @(negedge clk);
        check({tag, "_x"}, 32'(bus.out_x), 32'(x_exp));
        check({tag, "_flags"}, 32'({bus.overflow, bus.underflow, bus.exception}), 32'(f_exp));
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [15:0] ra, rb, rx;
        logic [2:0]  rf;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        vecs.push_back('{a: 16'h4200, b: 16'h3E00, x: 16'h4000, flags: 3'b000});
        vecs.push_back('{a: 16'h3C00, b: 16'h4200, x: 16'h3555, flags: 3'b000});
        vecs.push_back('{a: 16'hC600, b: 16'h4000, x: 16'hC200, flags: 3'b000});
        vecs.push_back('{a: 16'h3C00, b: 16'h0000, x: 16'h7FFF, flags: 3'b001});
        vecs.push_back('{a: 16'hBC00, b: 16'h0000, x: 16'hFFFF, flags: 3'b001});
        vecs.push_back('{a: 16'h0000, b: 16'h4000, x: 16'h0000, flags: 3'b000});
        vecs.push_back('{a: 16'h7FFF, b: 16'h0400, x: 16'h7FFF, flags: 3'b100});
        vecs.push_back('{a: 16'h0400, b: 16'h7C00, x: 16'h0000, flags: 3'b010});
        vecs.push_back('{a: 16'h0000, b: 16'h0000, x: 16'h7FFF, flags: 3'b001});
        vecs.push_back('{a: 16'h03FF, b: 16'h3C00, x: 16'h0000, flags: 3'b000});
        vecs.push_back('{a: 16'h8000, b: 16'h3C00, x: 16'h8000, flags: 3'b000});
        vecs.push_back('{a: 16'h3C00, b: 16'h3C00, x: 16'h3C00, flags: 3'b000});

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_x", 32'(bus.out_x), 32'd0);
        check("rst_flags", 32'({bus.overflow, bus.underflow, bus.exception}), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_and_check(vecs[i].a, vecs[i].b, vecs[i].x, vecs[i].flags,
                          $sformatf("vec%0d", i), 0);

        // Backpressure: result held while the input side is hammered.
        send(16'h4200, 16'h3E00);
        wait_result(lat);
        check("bp_lat", 32'(lat), 32'(LAT));
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 16'($urandom);
            bus.in_b     = 16'($urandom);
            @(negedge clk);
            check("bp_hold_x", 32'(bus.out_x), 32'h4000);
            check("bp_hold_flags", 32'({bus.overflow, bus.underflow, bus.exception}), 32'd0);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_a      = 16'hC600;
        bus.in_b      = 16'h4000;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_next_accepted", 32'(bus.in_ready), 32'd0);
        wait_result(lat);
        check("bp_next_lat", 32'(lat), 32'(LAT));
        check("bp_next_x", 32'(bus.out_x), 32'hC200);
        check("bp_next_flags", 32'({bus.overflow, bus.underflow, bus.exception}), 32'd0);
        drain();

        // Reset in the 5th DIV cycle aborts the operation.
        send(16'h4200, 16'h3E00);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        run_and_check(16'h4200, 16'h3E00, 16'h4000, 3'b000, "post_rst", 0);

        // Random operands with occasional zero exponents.
        for (int i = 0; i < 500; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 15) == 0) rb[14:10] = 5'd0;
            if ($urandom_range(0, 15) == 0) ra[14:10] = 5'd0;
            ref_div(ra, rb, rx, rf);
            run_and_check(ra, rb, rx, rf, $sformatf("rnd%0d_%h_%h", i, ra, rb),
                          int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Sequential floating-point divider: out_x = in_a / in_b, using the same sign/exponent/mantissa format and parameters as FpMult.
- Used wherever the datapath needs the inverse of FpMult, e.g. normalisation and rescale.
- Mantissa quotient is computed by iterative restoring division, one bit per cycle.
- Uses a valid/ready handshake on both input and output sides.

Parameters:
- W_MANTISSA, 10: stored mantissa bits; hidden leading 1 is implicit.
- W_EXPONENT, 5: biased exponent bits; BIAS = 2**(W_EXPONENT-1)-1.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operands valid.
- in_ready, output, 1: block can accept operands; high only in IDLE.
- in_a, input, W_MANTISSA+W_EXPONENT+1: dividend {sign, exponent, mantissa}.
- in_b, input, W_MANTISSA+W_EXPONENT+1: divisor, same format.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_x, output, W_MANTISSA+W_EXPONENT+1: quotient.
- overflow, output, 1: result saturated high; qualified by out_valid.
- underflow, output, 1: result flushed to zero; qualified by out_valid.
- exception, output, 1: divide by zero; qualified by out_valid.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - out_valid, out_x, overflow, underflow and exception are 0.
  - in_ready is 1.
  - Reset mid-operation aborts the operation; no result is ever presented.
- Number format:
  - Exponent 0 means zero. Denormal inputs are flushed to zero; the mantissa is ignored.
  - Exponents 1..2**W_EXPONENT-1 are all normal values. There is no Inf/NaN encoding.
- States: IDLE -> DIV -> NORM -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, register the operands, go to DIV, clear the iteration counter.
  - Capture these values:
    - sign = a.s ^ b.s.
    - exp = a.e - b.e + BIAS, signed, width W_EXPONENT+2.
    - remainder = {1,a.m}; divisor = {1,b.m}.
- DIV:
  - Runs exactly W_MANTISSA+2 cycles, one quotient bit per cycle, MSB first.
  - Each cycle: if remainder >= divisor, the quotient bit is 1 and remainder -= divisor; else the bit is 0. Then remainder <<= 1.
  - Quotient q is W_MANTISSA+2 bits: q[W_MANTISSA+1] has weight 2^0, q[0] has weight 2^-(W_MANTISSA+1). Result lies in (0.5, 2).
  - Counter reaching W_MANTISSA+1 moves to NORM.
- NORM (1 cycle), normalise then resolve special cases:
  - If q[W_MANTISSA+1]=1: mant = q[W_MANTISSA:1], exp unchanged. Else: mant = q[W_MANTISSA-1:0], exp = exp-1.
  - Rounding is truncation (toward zero); discarded bits are dropped.
  - b zero: out_x = {sign, all ones}, exception=1. This applies regardless of a.
  - Else a zero: out_x = {sign, all zeros}, no flags.
  - Else exp <= 0: out_x = {sign, zeros}, underflow=1.
  - Else exp > 2**W_EXPONENT-1: out_x = {sign, all ones}, overflow=1.
  - Else: out_x = {sign, exp[W_EXPONENT-1:0], mant}.
  - Go to DONE. At most one flag is set.
- DONE:
  - out_valid=1; out_x and flags are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE. out_valid falls and in_ready rises on the next cycle; no same-cycle re-accept.
- Timing:
  - Fixed latency regardless of operand values, including special cases, which still pass through DIV.
  - out_valid rises W_MANTISSA+3 cycles after the accepting edge (13 for the defaults).
  - Throughput is one divide per W_MANTISSA+5 cycles minimum.
- in_valid and operand changes outside IDLE are ignored.

Test Plan:
1. 3.0/1.5: in_a=0x4200, in_b=0x3E00 -> out_x=0x4000, flags 0, out_valid exactly 13 cycles after accept.
2. 1.0/3.0: 0x3C00/0x4200 -> 0x3555 (truncated). -6.0/2.0: 0xC600/0x4000 -> 0xC200.
3. Divide by zero:
   - 0x3C00/0x0000 -> 0x7FFF, exception=1.
   - 0xBC00/0x0000 -> 0xFFFF, exception=1.
   - 0x0000/0x4000 -> 0x0000, no flags.
4. Range limits:
   - 0x7FFF/0x0400 -> 0x7FFF, overflow=1.
   - 0x0400/0x7C00 -> 0x0000, underflow=1.
5. Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and changing in_a/in_b -> out_x and flags stable, in_ready=0. Release -> in_ready=1 one cycle later, and the next accepted operands produce the correct result.
6. Reset: assert rst_n=0 in the 5th DIV cycle -> out_valid=0 and in_ready=1 immediately. After release, a new 3.0/1.5 returns 0x4000 at latency 13. Randomised compare against a shortreal reference (truncated) over 500 vectors.
